// File: rtl/oracle_ev_pkg.sv
// Shared event types and constants for the oracle event tracker.
// ORACLE_RENAME_EV_EN adds the rename push slot and raises the stall threshold.
package oracle_ev_pkg;

  localparam int EV_XLEN = 64;
  localparam logic [31:0] INVALID_ID = 32'hFFFF_FFFF;

  localparam int STALL_THR_BASE = 8;
  localparam int STALL_THR_REN  = 10;

`ifdef ORACLE_RENAME_EV_EN
  localparam bit REN_EN = 1'b1;
`else
  localparam bit REN_EN = 1'b0;
`endif

  localparam int MAXPUSH   = REN_EN ? 5 : 4;
  localparam int STALL_THR = REN_EN ? STALL_THR_REN : STALL_THR_BASE;

  typedef enum logic [2:0] {
    EV_DEC = 3'd0,
    EV_REN = 3'd1,
    EV_ISS = 3'd2,
    EV_WB  = 3'd3,
    EV_CMT = 3'd4
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e           kind;
    logic [31:0]        id;
    logic [EV_XLEN-1:0] pc;
    logic [EV_XLEN-1:0] d0;
    logic [EV_XLEN-1:0] d1;
  } ev_t;

endpackage

// File: rtl/oracle_ev_fifo.sv
// Multi-push, single-pop event ring buffer; head is a register, so a push at t shows at t+1 when empty.
// Pushes beyond free space are dropped from the last slot backwards and flagged on drop.
module oracle_ev_fifo
  import oracle_ev_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int MAXPUSH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAXPUSH-1:0]       push_vld,
  input  ev_t                      push_dat [MAXPUSH],
  input  logic                     pop,
  output logic                     head_vld,
  output ev_t                      head_dat,
  output logic [$clog2(DEPTH):0]   free_next,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  ev_t             mem [DEPTH];
  logic [AW:0]     wptr, rptr, wptr_nxt, rptr_nxt;
  logic [AW:0]     used, free_cnt, push_cnt;
  logic            full, empty, do_pop;
  logic [MAXPUSH-1:0] wr_en;
  logic [AW-1:0]   wr_idx [MAXPUSH];
  ev_t             head_nxt;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign used     = wptr - rptr;
  assign free_cnt = full ? '0 : CAP - used;
  assign do_pop   = pop & ~empty;

  always_comb begin
    push_cnt = '0;
    drop     = 1'b0;
    wr_en    = '0;
    for (int i = 0; i < MAXPUSH; i++) begin
      wr_idx[i] = wptr[AW-1:0] + push_cnt[AW-1:0];
      if (push_vld[i]) begin
        if (push_cnt < free_cnt) begin
          wr_en[i] = 1'b1;
          push_cnt = push_cnt + ONE;
        end else begin
          drop = 1'b1;
        end
      end
    end

    rptr_nxt  = rptr + (do_pop ? ONE : '0);
    wptr_nxt  = wptr + push_cnt;
    free_next = CAP - (wptr_nxt - rptr_nxt);

    // Next head may be a slot written this very cycle.
    head_nxt = mem[rptr_nxt[AW-1:0]];
    for (int i = 0; i < MAXPUSH; i++) begin
      if (wr_en[i] && (wr_idx[i] == rptr_nxt[AW-1:0])) head_nxt = push_dat[i];
    end
    if (wptr_nxt == rptr_nxt) head_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      head_vld <= (wptr_nxt != rptr_nxt);
      head_dat <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAXPUSH; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= push_dat[i];
    end
  end

endmodule

// File: rtl/oracle_event_tracker.sv
// Tags decoded instructions with ids and serialises DEC/(REN with ORACLE_RENAME_EV_EN)/ISS/WB/CMT events; 1-cycle min latency.
// ev_ready_i backpressure fills the buffer and raises stall_o; overflowing late-order events are dropped and overflow_o sticks.
module oracle_event_tracker
  import oracle_ev_pkg::*;
#(
  parameter int NTAGS      = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int XLEN       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dec_valid_i,
  input  logic [$clog2(NTAGS)-1:0] dec_tag_i,
  input  logic [XLEN-1:0]          dec_pc_i,
  input  logic [31:0]              dec_inst_i,
`ifdef ORACLE_RENAME_EV_EN
  input  logic                     ren_valid_i,
  input  logic [$clog2(NTAGS)-1:0] ren_tag_i,
  input  logic [7:0]               ren_prs1_i,
  input  logic [7:0]               ren_prs1r_i,
  input  logic [7:0]               ren_prs2_i,
  input  logic [7:0]               ren_prs2r_i,
  input  logic [7:0]               ren_prd_i,
`endif
  input  logic                     iss_valid_i,
  input  logic [$clog2(NTAGS)-1:0] iss_tag_i,
  input  logic [XLEN-1:0]          iss_rs1_i,
  input  logic [XLEN-1:0]          iss_rs2_i,
  input  logic                     wb_valid_i,
  input  logic [$clog2(NTAGS)-1:0] wb_tag_i,
  input  logic [XLEN-1:0]          wb_rd_i,
  input  logic                     cmt_valid_i,
  input  logic [$clog2(NTAGS)-1:0] cmt_tag_i,
  output logic                     stall_o,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic [2:0]               ev_kind_o,
  output logic [31:0]              ev_id_o,
  output logic [XLEN-1:0]          ev_pc_o,
  output logic [XLEN-1:0]          ev_d0_o,
  output logic [XLEN-1:0]          ev_d1_o,
  output logic                     overflow_o
);

  localparam int TW    = $clog2(NTAGS);
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int S_ISS = MAXPUSH - 3;
  localparam int S_WB  = MAXPUSH - 2;
  localparam int S_CMT = MAXPUSH - 1;
  localparam logic [FAW:0] THR = (FAW+1)'(STALL_THR);

  logic [31:0]     next_id;
  logic [31:0]     tbl_id [NTAGS];
  logic [XLEN-1:0] tbl_pc [NTAGS];
  logic [NTAGS-1:0] tbl_vld;

  logic [MAXPUSH-1:0] push_vld;
  ev_t             push_dat [MAXPUSH];
  ev_t             head;
  logic [FAW:0]    free_next;
  logic            fifo_drop;

  // A same-cycle decode to the tag wins over the stored entry.
  function automatic ev_t tag_ev(input ev_kind_e k, input logic [TW-1:0] tag);
    ev_t e;
    e      = '0;
    e.kind = k;
    if (dec_valid_i && (dec_tag_i == tag)) begin
      e.id = next_id;
      e.pc = dec_pc_i;
    end else if (tbl_vld[tag]) begin
      e.id = tbl_id[tag];
      e.pc = tbl_pc[tag];
    end else begin
      e.id = INVALID_ID;
      e.pc = '0;
    end
    return e;
  endfunction

  always_comb begin
    push_vld = '0;
    for (int i = 0; i < MAXPUSH; i++) push_dat[i] = '0;

    push_vld[0]      = dec_valid_i;
    push_dat[0].kind = EV_DEC;
    push_dat[0].id   = next_id;
    push_dat[0].pc   = dec_pc_i;
    push_dat[0].d0   = EV_XLEN'(dec_inst_i);

`ifdef ORACLE_RENAME_EV_EN
    push_vld[1]    = ren_valid_i;
    push_dat[1]    = tag_ev(EV_REN, ren_tag_i);
    push_dat[1].d0 = EV_XLEN'({ren_prs1_i, ren_prs1r_i, ren_prs2_i, ren_prs2r_i});
    push_dat[1].d1 = EV_XLEN'(ren_prd_i);
`endif

    push_vld[S_ISS]    = iss_valid_i;
    push_dat[S_ISS]    = tag_ev(EV_ISS, iss_tag_i);
    push_dat[S_ISS].d0 = iss_rs1_i;
    push_dat[S_ISS].d1 = iss_rs2_i;

    push_vld[S_WB]    = wb_valid_i;
    push_dat[S_WB]    = tag_ev(EV_WB, wb_tag_i);
    push_dat[S_WB].d0 = wb_rd_i;

    push_vld[S_CMT] = cmt_valid_i;
    push_dat[S_CMT] = tag_ev(EV_CMT, cmt_tag_i);
  end

  oracle_ev_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .MAXPUSH (MAXPUSH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push_vld  (push_vld),
    .push_dat  (push_dat),
    .pop       (ev_ready_i),
    .head_vld  (ev_valid_o),
    .head_dat  (head),
    .free_next (free_next),
    .drop      (fifo_drop)
  );

  assign ev_kind_o = head.kind;
  assign ev_id_o   = head.id;
  assign ev_pc_o   = head.pc;
  assign ev_d0_o   = head.d0;
  assign ev_d1_o   = head.d1;

  // Commit after decode in the same cycle leaves the entry invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      next_id    <= '0;
      tbl_vld    <= '0;
      stall_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (dec_valid_i) begin
        tbl_vld[dec_tag_i] <= 1'b1;
        next_id            <= next_id + 32'd1;
      end
      if (cmt_valid_i) tbl_vld[cmt_tag_i] <= 1'b0;
      if (fifo_drop) overflow_o <= 1'b1;
      stall_o <= (free_next < THR);
    end
  end

  always_ff @(posedge clk_i) begin
    if (dec_valid_i) begin
      tbl_id[dec_tag_i] <= next_id;
      tbl_pc[dec_tag_i] <= dec_pc_i;
    end
  end

endmodule

// File: doc/oracle_event_tracker.md
Name: oracle_event_tracker

Overview:
- RTL-side producer for the core oracle.
- Captures per-instruction lifecycle strobes from the pipeline: decode, issue, write-back, commit.
- Assigns each decoded instruction a monotonically increasing 32-bit id and remembers its {id, pc} per in-flight tag.
- Serialises all events in program-causal order onto one valid/ready event stream; the DPI bridge consumes that stream and calls the oracle handlers.

Parameters:
- NTAGS, 16, number of in-flight instruction tags (ROB slots); power of two.
- FIFO_DEPTH, 32, event buffer entries; power of two, at least 8.
- XLEN, 64, pc/data width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- dec_valid_i  in  1  decode event strobe
- dec_tag_i  in  log2(NTAGS)  tag allocated at decode
- dec_pc_i  in  XLEN  decoded pc
- dec_inst_i  in  32  raw instruction
- iss_valid_i  in  1  issue event strobe
- iss_tag_i  in  log2(NTAGS)  issued tag
- iss_rs1_i, iss_rs2_i  in  XLEN each  operand values
- wb_valid_i  in  1  write-back strobe
- wb_tag_i  in  log2(NTAGS)  write-back tag
- wb_rd_i  in  XLEN  result value
- cmt_valid_i  in  1  commit strobe
- cmt_tag_i  in  log2(NTAGS)  committed tag
- stall_o  out  1  pipeline must not emit new strobes next cycle
- ev_valid_o  out  1  event available
- ev_ready_i  in  1  consumer accepts event
- ev_kind_o  out  3  event kind (DEC=0, REN=1, ISS=2, WB=3, CMT=4)
- ev_id_o  out  32  instruction id
- ev_pc_o  out  XLEN  instruction pc
- ev_d0_o, ev_d1_o  out  XLEN each  payload (DEC: d0={inst}; ISS: rs1/rs2; WB: d0=rd; CMT: 0)
- overflow_o  out  1  sticky, an event was dropped

Behaviour:
- Reset (async, rst_i=1): id counter=0; FIFO empty; ev_valid_o=0; all ev_* data outputs=0; stall_o=0; overflow_o=0; tag table valid bits cleared.
- Decode:
  - Writes table[dec_tag_i] = {next_id, dec_pc_i, valid=1}.
  - next_id increments by 1 and wraps 2^32-1 -> 0.
  - The DEC event carries the id just assigned.
- ISS/WB/CMT events read id and pc from the table at their tag.
  - A decode to tag T and another event to the same tag T in the same cycle: the other event sees the new entry (bypass).
- Commit clears table[tag].valid.
- An ISS/WB/CMT strobe to an invalid tag is still enqueued, with id=0xFFFF_FFFF and pc=0.
- Same-cycle ordering: up to 4 events are pushed in order DEC, ISS, WB, CMT into consecutive FIFO slots (multi-push ring buffer).
- Pop: one event per cycle when ev_valid_o && ev_ready_i.
- Outputs are registered from the FIFO head. ev_* is stable while ev_valid_o=1 and ev_ready_i=0.
- Latency: a strobe in cycle t is visible on ev_* at t+1 at the earliest, when the FIFO is empty.
- stall_o=1 when free entries < 8, which guarantees 2 cycles of worst-case pushes. stall_o is registered.
- Full: pushes beyond free space are dropped oldest-kind-last (CMT dropped first) and overflow_o latches 1 until reset.
- Simultaneous push and pop: the free count is updated net.
- Wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are determined by MSB compare.

Optional Feature:
- ORACLE_RENAME_EV_EN
- When defined:
  - Adds ports ren_valid_i (1), ren_tag_i, ren_prs1_i (8), ren_prs1r_i (8), ren_prs2_i (8), ren_prs2r_i (8), ren_prd_i (8).
  - Emits REN events, pushed between DEC and ISS, for up to 5 pushes per cycle.
  - d0 = {prs1, prs1r, prs2, prs2r} zero-extended; d1 = prd.
  - The stall threshold becomes 10.
- When undefined: no rename ports, kind 1 never produced, stall threshold 8.

Decomposition:
- Package oracle_ev_pkg:
  - ev_kind_e enum.
  - ev_t struct {kind, id, pc, d0, d1}.
  - INVALID_ID constant 0xFFFF_FFFF.
  - Stall-threshold constants.
- Sub-module oracle_ev_fifo: parameterised multi-push (MAXPUSH), single-pop ring buffer of ev_t.

Test Plan:
- Reset, then DEC tag 3 pc 0x8000_0000 inst 0x0000_0013 with ev_ready_i=1 -> next cycle ev_valid_o=1, kind DEC, id 0, pc 0x8000_0000, d0=0x13.
- Same cycle: DEC tag 2 plus CMT tag 5 (tag 5 decoded earlier as id 7, pc 0x8000_0010) -> DEC (id N) popped first, then CMT id 7 pc 0x8000_0010.
- Same-cycle DEC and ISS to tag 4 with rs1=0x11, rs2=0x22 -> ISS event carries the freshly assigned id (bypass); d0=0x11, d1=0x22.
- Hold ev_ready_i=0 and strobe 4 events/cycle -> stall_o rises when free < 8; ev_* stays stable; after further forced pushes overflow_o=1 and stays 1.
- Preload id counter path with 2^32 decodes (force) -> ids ...FFFF_FFFE, FFFF_FFFF, 0.
- CMT to never-decoded tag 9 -> event id 0xFFFF_FFFF, pc 0; with ORACLE_RENAME_EV_EN, REN on tag 1 (prs1=5, prs1r=40, prd=41) appears between its DEC and ISS.
